alu_accumulator_unit: RTL and testbench

Four-bit ALU/shifter datapath with a registered accumulator stage.
- The combinational part decodes a 4-bit mode into arithmetic, logic or shift results plus a carry/overflow flag.
- The accumulator registers the 5-bit result {flag, result} on each clock edge.
- Sits as the execute and writeback stage of the lab CPU datapath.

---
 rtl/alu_accumulator_unit_pkg.sv | 32 +++
 rtl/alu_accumulator_unit_if.sv | 32 +++
 rtl/alu_shifter_core.sv | 77 +++++++
 rtl/alu_accumulator_unit.sv | 50 +++++
 tb/tb_alu_accumulator_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_accumulator_unit_pkg.sv
// ============================================================================
// alu_pkg : shared mode encoding and default datapath width for the ALU unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [3:0] {
    MODE_ADD   = 4'd0,
    MODE_SUB   = 4'd1,
    MODE_INC   = 4'd2,
    MODE_DEC   = 4'd3,
    MODE_AND   = 4'd4,
    MODE_OR    = 4'd5,
    MODE_XOR   = 4'd6,
    MODE_NOT   = 4'd7,
    MODE_SLL   = 4'd8,
    MODE_SRL   = 4'd9,
    MODE_SRA   = 4'd10,
    MODE_ROL   = 4'd11,
    MODE_ROR   = 4'd12,
    MODE_SLC   = 4'd13,
    MODE_SRC   = 4'd14,
    MODE_PASSB = 4'd15
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/alu_accumulator_unit_if.sv
// ============================================================================
// alu_accumulator_unit_if : operand/mode inputs and result/accumulator outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_accumulator_unit_if #(
  parameter int WIDTH = alu_pkg::WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  alu_pkg::mode_e   Mode;
  logic [WIDTH-1:0] R;
  logic             OverFlow;
  logic [WIDTH-1:0] Y;
  logic             CBF;

  modport master (
    output A, B, Cin, Mode,
    input  R, OverFlow, Y, CBF
  );

  modport slave (
    input  A, B, Cin, Mode,
    output R, OverFlow, Y, CBF
  );

endinterface

`default_nettype wire

// File: rtl/alu_shifter_core.sv
// ============================================================================
// alu_shifter_core : combinational ALU/shifter producing result and flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_shifter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] r_o,
  output logic             ovf_o
);

  logic [WIDTH:0] sum_add;
  logic [WIDTH:0] sum_sub;
  logic [WIDTH:0] sum_inc;
  logic [WIDTH:0] diff_dec;

  // One extra bit on every arithmetic path so the top bit is the carry/borrow
  assign sum_add  = {1'b0, a_i} + {1'b0, b_i}  + {{WIDTH{1'b0}}, cin_i};
  assign sum_sub  = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, cin_i};
  assign sum_inc  = {1'b0, a_i} + (WIDTH+1)'(1);
  assign diff_dec = {1'b0, a_i} - (WIDTH+1)'(1);

  always_comb begin
    r_o   = '0;
    ovf_o = 1'b0;
    case (mode_i)
      MODE_ADD:   {ovf_o, r_o} = sum_add;
      MODE_SUB:   {ovf_o, r_o} = sum_sub;
      MODE_INC:   {ovf_o, r_o} = sum_inc;
      MODE_DEC:   {ovf_o, r_o} = diff_dec;
      MODE_AND:   r_o = a_i & b_i;
      MODE_OR:    r_o = a_i | b_i;
      MODE_XOR:   r_o = a_i ^ b_i;
      MODE_NOT:   r_o = ~a_i;
      MODE_SLL: begin
        r_o   = {a_i[WIDTH-2:0], 1'b0};
        ovf_o = a_i[WIDTH-1];
      end
      MODE_SRL: begin
        r_o   = {1'b0, a_i[WIDTH-1:1]};
        ovf_o = a_i[0];
      end
      MODE_SRA: begin
        r_o   = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
        ovf_o = a_i[0];
      end
      MODE_ROL: begin
        r_o   = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
        ovf_o = a_i[WIDTH-1];
      end
      MODE_ROR: begin
        r_o   = {a_i[0], a_i[WIDTH-1:1]};
        ovf_o = a_i[0];
      end
      MODE_SLC: begin
        r_o   = {a_i[WIDTH-2:0], cin_i};
        ovf_o = a_i[WIDTH-1];
      end
      MODE_SRC: begin
        r_o   = {cin_i, a_i[WIDTH-1:1]};
        ovf_o = a_i[0];
      end
      MODE_PASSB: r_o = b_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_accumulator_unit.sv
// ============================================================================
// alu_accumulator_unit : ALU/shifter followed by a {flag, result} accumulator
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_accumulator_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic                   Clk,
  input  logic                   Reset,
  alu_accumulator_unit_if.slave  bus
);

  logic [WIDTH-1:0] alu_r;
  logic             alu_ovf;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH:0]   acc_q;

  alu_shifter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i    (bus.A),
    .b_i    (bus.B),
    .cin_i  (bus.Cin),
    .mode_i (bus.Mode),
    .r_o    (alu_r),
    .ovf_o  (alu_ovf)
  );

  assign acc_d = {alu_ovf, alu_r};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign bus.R        = alu_r;
  assign bus.OverFlow = alu_ovf;
  assign bus.Y        = acc_q[WIDTH-1:0];
  assign bus.CBF      = acc_q[WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_alu_accumulator_unit.sv
// ============================================================================
// tb_alu_accumulator_unit : directed self-checking bench for the ALU unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_accumulator_unit;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_accumulator_unit_if #(.WIDTH(4)) bus ();

  alu_accumulator_unit #(
    .WIDTH (4)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; combinational outputs are sampled 1ns later
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c, input mode_e m);
    @(negedge clk);
    bus.A    = a;
    bus.B    = b;
    bus.Cin  = c;
    bus.Mode = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (bus.Y !== 4'b0000 || bus.CBF !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got Y=%b CBF=%b want Y=0000 CBF=0", bus.Y, bus.CBF);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    drive(4'b1111, 4'b1110, 1'b0, MODE_ADD);
    total++;
    if (bus.R !== 4'b1101 || bus.OverFlow !== 1'b1) begin
      bad++;
      $display("FAIL add_comb: got R=%b OV=%b want R=1101 OV=1", bus.R, bus.OverFlow);
    end
    tick();
    total++;
    if (bus.Y !== 4'b1101 || bus.CBF !== 1'b1) begin
      bad++;
      $display("FAIL add_reg: got Y=%b CBF=%b want Y=1101 CBF=1", bus.Y, bus.CBF);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.Y !== 4'b0000 || bus.CBF !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got Y=%b CBF=%b want Y=0000 CBF=0", bus.Y, bus.CBF);
    end
    tick();
    total++;
    if (bus.Y !== 4'b0000 || bus.CBF !== 1'b0) begin
      bad++;
      $display("FAIL reset_held_edge: got Y=%b CBF=%b want Y=0000 CBF=0", bus.Y, bus.CBF);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sub();
    logic [3:0] va [2] = '{4'b1001, 4'b1101};
    logic [3:0] vb [2] = '{4'b1101, 4'b1001};
    logic [3:0] er [2] = '{4'b1100, 4'b0100};
    logic       ef [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      drive(va[i], vb[i], 1'b1, MODE_SUB);
      total++;
      if (bus.R !== er[i] || bus.OverFlow !== ef[i]) begin
        bad++;
        $display("FAIL sub_comb[%0d]: got R=%b OV=%b want R=%b OV=%b", i, bus.R, bus.OverFlow, er[i], ef[i]);
      end
      tick();
      total++;
      if (bus.Y !== er[i] || bus.CBF !== ef[i]) begin
        bad++;
        $display("FAIL sub_reg[%0d]: got Y=%b CBF=%b want Y=%b CBF=%b", i, bus.Y, bus.CBF, er[i], ef[i]);
      end
    end
  endtask

  // Cin held high to confirm INC/DEC ignore it
  task automatic test_inc_dec();
    logic [3:0] va [3] = '{4'b1111, 4'b0000, 4'b0100};
    mode_e      vm [3] = '{MODE_INC, MODE_DEC, MODE_DEC};
    logic [3:0] er [3] = '{4'b0000, 4'b1111, 4'b0011};
    logic       ef [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(va[i], 4'b0110, 1'b1, vm[i]);
      total++;
      if (bus.R !== er[i] || bus.OverFlow !== ef[i]) begin
        bad++;
        $display("FAIL incdec_comb[%0d]: got R=%b OV=%b want R=%b OV=%b", i, bus.R, bus.OverFlow, er[i], ef[i]);
      end
      tick();
      total++;
      if (bus.Y !== er[i] || bus.CBF !== ef[i]) begin
        bad++;
        $display("FAIL incdec_reg[%0d]: got Y=%b CBF=%b want Y=%b CBF=%b", i, bus.Y, bus.CBF, er[i], ef[i]);
      end
    end
  endtask

  task automatic test_logic();
    mode_e      vm [5] = '{MODE_AND, MODE_OR, MODE_XOR, MODE_NOT, MODE_PASSB};
    logic [3:0] er [5] = '{4'b0100, 4'b1101, 4'b1001, 4'b0011, 4'b0101};
    for (int i = 0; i < 5; i++) begin
      drive(4'b1100, 4'b0101, 1'b1, vm[i]);
      total++;
      if (bus.R !== er[i] || bus.OverFlow !== 1'b0) begin
        bad++;
        $display("FAIL logic_comb[%0d]: got R=%b OV=%b want R=%b OV=0", i, bus.R, bus.OverFlow, er[i]);
      end
    end
  endtask

  task automatic test_shift();
    mode_e      vm [7] = '{MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR, MODE_SLC, MODE_SRC};
    logic [3:0] er [7] = '{4'b0010, 4'b0100, 4'b1100, 4'b0011, 4'b1100, 4'b0011, 4'b1100};
    for (int i = 0; i < 7; i++) begin
      drive(4'b1001, 4'b0000, 1'b1, vm[i]);
      total++;
      if (bus.R !== er[i] || bus.OverFlow !== 1'b1) begin
        bad++;
        $display("FAIL shift_comb[%0d]: got R=%b OV=%b want R=%b OV=1", i, bus.R, bus.OverFlow, er[i]);
      end
    end
  endtask

  // One vector per mode; a reset pulse is inserted while vector 8 is applied
  task automatic test_sweep();
    logic [3:0] va [16] = '{4'b0110, 4'b0011, 4'b0111, 4'b1000, 4'b1010, 4'b1010, 4'b1111, 4'b0110,
                            4'b0110, 4'b0110, 4'b1010, 4'b1010, 4'b0110, 4'b0100, 4'b0010, 4'b0000};
    logic [3:0] vb [16] = '{4'b0011, 4'b0110, 4'b0000, 4'b0000, 4'b0110, 4'b0101, 4'b0101, 4'b0000,
                            4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1011};
    logic       vc [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] er [16] = '{4'b1010, 4'b1101, 4'b1000, 4'b0111, 4'b0010, 4'b1111, 4'b1010, 4'b1001,
                            4'b1100, 4'b0011, 4'b1101, 4'b0101, 4'b0011, 4'b1001, 4'b0001, 4'b1011};
    logic       ef [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      drive(va[i], vb[i], vc[i], mode_e'(i));
      total++;
      if (bus.R !== er[i] || bus.OverFlow !== ef[i]) begin
        bad++;
        $display("FAIL sweep_comb[%0d]: got R=%b OV=%b want R=%b OV=%b", i, bus.R, bus.OverFlow, er[i], ef[i]);
      end
      if (i == 8) begin
        rst = 1'b1;
        #1;
        total++;
        if (bus.Y !== 4'b0000 || bus.CBF !== 1'b0) begin
          bad++;
          $display("FAIL sweep_rst_async: got Y=%b CBF=%b want Y=0000 CBF=0", bus.Y, bus.CBF);
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (bus.Y !== 4'b0000 || bus.CBF !== 1'b0) begin
          bad++;
          $display("FAIL sweep_rst_release: got Y=%b CBF=%b want Y=0000 CBF=0", bus.Y, bus.CBF);
        end
      end
      tick();
      total++;
      if (bus.Y !== er[i] || bus.CBF !== ef[i]) begin
        bad++;
        $display("FAIL sweep_reg[%0d]: got Y=%b CBF=%b want Y=%b CBF=%b", i, bus.Y, bus.CBF, er[i], ef[i]);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    bus.A    = 4'b0000;
    bus.B    = 4'b0000;
    bus.Cin  = 1'b0;
    bus.Mode = MODE_ADD;
    test_reset();
    test_add();
    test_async_reset();
    test_sub();
    test_inc_dec();
    test_logic();
    test_shift();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
